// File: rtl/log2_pkg.sv
// Shared types and default sizes for the floor(log2) block and its step datapath.
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned default_width_lp     = 32;
  localparam int unsigned default_out_width_lp = 32;

endpackage

// File: rtl/log2_step.sv
// One reduction step of the log2 search: shift the operand right by stride when anything
// survives the shift, folding the discarded bits into the sticky (inexact) flag.
module log2_step #(
  parameter int unsigned width_p = 32,
  parameter int unsigned cnt_w_p = 5
) (
  input  logic [width_p-1:0] operand_i,
  input  logic [cnt_w_p-1:0] count_i,
  input  logic               sticky_i,
  input  logic [cnt_w_p-1:0] stride_i,
  output logic [width_p-1:0] operand_o,
  output logic [cnt_w_p-1:0] count_o,
  output logic               sticky_o,
  output logic               done_o
);

  logic [width_p-1:0] shifted;
  logic [width_p-1:0] low_mask;

  assign shifted  = operand_i >> stride_i;
  assign low_mask = (width_p'(1) << stride_i) - width_p'(1);
  // done means the leading one is already at or below bit stride-1
  assign done_o   = (shifted == '0);

  always_comb begin
    operand_o = operand_i;
    count_o   = count_i;
    sticky_o  = sticky_i;
    if (!done_o) begin
      operand_o = shifted;
      count_o   = count_i + stride_i;
      sticky_o  = sticky_i | (|(operand_i & low_mask));
    end
  end

endmodule

// File: rtl/log2.sv
// Multi-cycle floor(log2) with exact/zero flags; valid/ready in, valid/yumi out.
// Define LOG2_BSEARCH_EN for a fixed-latency binary search instead of the serial shift.
module log2
  import log2_pkg::*;
#(
  parameter int unsigned width_p     = default_width_lp,
  parameter int unsigned out_width_p = default_out_width_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   exact_o,
  output logic                   zero_o,
  output logic                   v_o,
  input  logic                   yumi_i
);

  localparam int unsigned lg_width_lp = $clog2(width_p);

  state_e                 state_q, state_d;
  logic [width_p-1:0]     operand_q, operand_d;
  logic [lg_width_lp-1:0] count_q, count_d;
  logic                   sticky_q, sticky_d;
  logic                   exact_q, exact_d;
  logic                   zero_q, zero_d;

  logic [width_p-1:0]     step_operand;
  logic [lg_width_lp-1:0] step_count;
  logic                   step_sticky;
  logic                   step_done;
  logic [lg_width_lp-1:0] stride;
  logic                   last_step;

`ifdef LOG2_BSEARCH_EN
  logic [lg_width_lp-1:0] stride_q, stride_d;
  logic                   unused_step_done;

  // fixed number of halving steps; early termination would break the constant latency
  assign stride           = stride_q;
  assign last_step        = (stride_q == lg_width_lp'(1));
  assign unused_step_done = step_done;
`else
  assign stride    = lg_width_lp'(1);
  assign last_step = step_done;
`endif

  log2_step #(
    .width_p (width_p),
    .cnt_w_p (lg_width_lp)
  ) u_step (
    .operand_i (operand_q),
    .count_i   (count_q),
    .sticky_i  (sticky_q),
    .stride_i  (stride),
    .operand_o (step_operand),
    .count_o   (step_count),
    .sticky_o  (step_sticky),
    .done_o    (step_done)
  );

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    count_d   = count_q;
    sticky_d  = sticky_q;
    exact_d   = exact_q;
    zero_d    = zero_q;
`ifdef LOG2_BSEARCH_EN
    stride_d  = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (v_i) begin
          count_d  = '0;
          sticky_d = 1'b0;
          exact_d  = 1'b0;
          if (data_i == '0) begin
            zero_d    = 1'b1;
            operand_d = '0;
            state_d   = DONE;
          end else begin
            zero_d    = 1'b0;
            operand_d = data_i;
            state_d   = BUSY;
`ifdef LOG2_BSEARCH_EN
            stride_d  = lg_width_lp'(width_p / 2);
`endif
          end
        end
      end
      BUSY: begin
        // a finishing step passes its inputs through unchanged, so step_sticky is final
        operand_d = step_operand;
        count_d   = step_count;
        sticky_d  = step_sticky;
`ifdef LOG2_BSEARCH_EN
        stride_d  = stride_q >> 1;
`endif
        if (last_step) begin
          exact_d = ~step_sticky;
          state_d = DONE;
        end
      end
      DONE: begin
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      operand_q <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
      exact_q   <= 1'b0;
      zero_q    <= 1'b0;
`ifdef LOG2_BSEARCH_EN
      stride_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
      exact_q   <= exact_d;
      zero_q    <= zero_d;
`ifdef LOG2_BSEARCH_EN
      stride_q  <= stride_d;
`endif
    end
  end

  assign ready_o = (state_q == IDLE);
  assign v_o     = (state_q == DONE);
  assign exact_o = exact_q;
  assign zero_o  = zero_q;

  always_comb begin
    data_o                  = '0;
    data_o[lg_width_lp-1:0] = count_q;
  end

endmodule

// File: tb/tb_log2.sv
// Directed bench for log2 (32-bit): results, flags, latency, back-pressure and mid-operation reset.
module tb_log2;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        exact_o;
  logic        zero_o;
  logic        v_o;
  logic        yumi_i;

  int checks = 0;
  int errors = 0;

  log2 #(.width_p(32), .out_width_p(32)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .exact_o   (exact_o),
    .zero_o    (zero_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // serial latency is floor(log2)+1; binary search is a fixed 5 steps for nonzero operands
  function automatic int exp_latency(input int serial_lat, input logic is_zero);
`ifdef LOG2_BSEARCH_EN
    return is_zero ? 0 : 5;
`else
    return serial_lat;
`endif
  endfunction

  task automatic take_result();
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check("v_o_after_yumi", 32'(v_o), 32'd0);
    check("ready_after_yumi", 32'(ready_o), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] d, input int exp_res, input logic exp_exact,
                        input logic exp_zero, input int serial_lat, input bit take);
    int lat;
    lat = 0;
    while (!ready_o && lat < 50) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("ready_before_accept", 32'(ready_o), 32'd1);
    data_i = d;
    v_i    = 1'b1;
    @(posedge clk_i); #1;
    v_i    = 1'b0;
    data_i = '0;
    lat = 0;
    while (!v_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_latency(serial_lat, exp_zero)));
    check("data_o", data_o, 32'(exp_res));
    check("exact_o", 32'(exact_o), 32'(exp_exact));
    check("zero_o", 32'(zero_o), 32'(exp_zero));
    $display("op data_i=%08h -> data_o=%0d exact=%0d zero=%0d latency=%0d",
             d, data_o, exact_o, zero_o, lat);
    if (take) take_result();
  endtask

  initial begin
    bit seen;
    logic [31:0] pw;
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    yumi_i    = 1'b0;
    data_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_v_o", 32'(v_o), 32'd0);
    check("reset_data", data_o, 32'd0);
    check("reset_exact", 32'(exact_o), 32'd0);
    check("reset_zero", 32'(zero_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // directed vectors: operand, floor(log2), exact, zero, serial latency
    run_op(32'h0000_0001, 0,  1'b1, 1'b0, 1,  1'b1);
    run_op(32'h8000_0000, 31, 1'b1, 1'b0, 32, 1'b1);
    run_op(32'h0000_0600, 10, 1'b0, 1'b0, 11, 1'b1);
    run_op(32'h0000_0000, 0,  1'b0, 1'b1, 0,  1'b1);
    run_op(32'h0000_0003, 1,  1'b0, 1'b0, 2,  1'b1);
    run_op(32'hFFFF_FFFF, 31, 1'b0, 1'b0, 32, 1'b1);
    run_op(32'h0000_0010, 4,  1'b1, 1'b0, 5,  1'b1);

    // back-pressure: result held, ready low, a v_i pulse is ignored
    run_op(32'h0000_0600, 10, 1'b0, 1'b0, 11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        data_i = 32'h0000_FFFF;
        v_i    = 1'b1;
      end else begin
        v_i    = 1'b0;
      end
      @(posedge clk_i); #1;
      check("hold_v_o", 32'(v_o), 32'd1);
      check("hold_data", data_o, 32'd10);
      check("hold_exact", 32'(exact_o), 32'd0);
      check("hold_ready", 32'(ready_o), 32'd0);
    end
    v_i    = 1'b0;
    data_i = '0;
    take_result();
    run_op(32'h0000_FFFF, 15, 1'b0, 1'b0, 16, 1'b1);

    // reset in the middle of BUSY aborts the operand with no stale result
    data_i = 32'h8000_0000;
    v_i    = 1'b1;
    @(posedge clk_i); #1;
    v_i    = 1'b0;
    data_i = '0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("busy_before_reset", 32'(ready_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    check("midreset_v_o", 32'(v_o), 32'd0);
    check("midreset_ready", 32'(ready_o), 32'd1);
    check("midreset_data", data_o, 32'd0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      seen |= v_o;
    end
    check("no_stale_result", 32'(seen), 32'd0);
    run_op(32'h0000_0005, 2, 1'b0, 1'b0, 3, 1'b1);

    // pow2 chain model: each power of two must round-trip through its exponent
    for (int k = 0; k < 32; k++) begin
      pw = 32'd1 << k;
      run_op(pw, k, 1'b1, 1'b0, k + 1, 1'b0);
      check("pow2_roundtrip", 32'd1 << data_o, pw);
      take_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
